sha256_core: RTL and testbench
==============================

// Module: sha256_core
// PURPOSE
// - Single-block SHA-256 compression engine with its own constant store (hk_mem).
// - After reset it fills hk_mem with H0..H7 and K0..K63, then hashes 512-bit padded blocks on request.
// - Sits between the message padder (upstream) and the digest consumer (downstream).
// PARAMETERS
// - HK_WORDS  72  hk_mem depth: 8 H words followed by 64 K words.
// - INIT_CYC  1   cycles spent per hk_mem word write during init.
// PORTS
// - CLK        in   1    clock; all logic on rising edge.
// - RST        in   1    reset; synchronous, active-high.
// - START      in   1    hash request, sampled only in READY.
// - BLOCK      in   512  padded message block; BLOCK[511:480] is W0. Captured when START is accepted.
// - INIT_DONE  out  1    high once hk_mem is loaded; stays high until the next RST.
// - BUSY       out  1    high from START acceptance until DONE.
// - DONE       out  1    one-cycle pulse when DIGEST is valid.
// - DIGEST     out  256  {H0'..H7'}; H0' in [255:224]; held until the next DONE.
// BEHAVIOUR
// - Reset values: INIT_DONE=0, BUSY=0, DONE=0, DIGEST=0, state=MEM_INIT, init address=0.
// - hk_mem storage:
//   - 72 x 32 bits, split into four byte banks: bank_1=[31:24], bank_2=[23:16], bank_3=[15:8], bank_4=[7:0].
//   - Each bank has a buffer[] array.
//   - Read is synchronous with 1-cycle latency.
// - State MEM_INIT: writes word a (a=0..71) from a constant ROM, one word per cycle.
//   - a=0..7 are the FIPS 180-4 IV values 6a09e667..5be0cd19.
//   - a=8..71 are K0..K63.
// - State MEM_INIT_DONE: entered after a=71 is written and lasts 1 cycle; INIT_DONE rises there.
//   - hk_mem is complete and stable on entry.
//   - MEM_INIT_DONE is a named localparam of the state register `state`.
// - State READY: idle.
//   - START=1 captures BLOCK into a 16-word schedule window.
//   - Loads a..h from the H registers; goes to ROUND with t=0.
//   - START while in MEM_INIT or MEM_INIT_DONE is ignored; no queuing.
// - State ROUND: one round per cycle for t=0..63.
//   - K[t] is read from hk_mem address 8+t, prefetched one cycle ahead.
//   - W[t] for t>=16 = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], computed in the sliding window.
//   - All additions are mod 2^32.
// - State FINAL (1 cycle):
//   - H_i' = H_i + working var_i.
//   - DIGEST updated, DONE=1, BUSY drops.
//   - Return to READY.
// - Latency: START accepted on edge N gives DONE high in cycle N+66 (1 load + 64 rounds + 1 final).
// - A START held high at DONE is sampled again in READY on the next cycle.
// - RST asserted in any state (including mid-ROUND):
//   - Next state is MEM_INIT; outputs return to reset values.
//   - The partial hash is discarded and hk_mem is re-initialised.
// - Without chaining, the H working registers are loaded from hk_mem[0..7] (the IV) on every START.
// CONFIGURATION
// - SHA256_CHAIN_EN defined:
//   - Adds input FIRST (1 bit), sampled with START.
//   - FIRST=1 uses the IV from hk_mem; FIRST=0 uses the previous DIGEST as H, for multi-block messages.
// - SHA256_CHAIN_EN undefined: no FIRST port; every block starts from the IV.
// TESTING
// - RST 1 cycle, then run:
//   - INIT_DONE by cycle 74.
//   - In MEM_INIT_DONE, {bank_1..bank_4}.buffer[i] for i=0..7 equals 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19.
//   - Word 8 = 428a2f98; word 71 = c67178f2.
// - Padded "abc" block (61626380, zeros, last word 00000018)
//   -> DONE 66 cycles after START.
//   -> DIGEST = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
// - Empty-message block (80000000, then all zeros)
//   -> DIGEST = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
// - START pulsed during MEM_INIT -> ignored: BUSY stays 0, no DONE.
// - RST at round t=30, then re-init, then "abc" -> correct abc digest, with no DONE from the aborted run.
// - With SHA256_CHAIN_EN: two-block "abcdbcde...nopq" (FIRST=1, then FIRST=0)
//   -> DIGEST = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.

Source files
------------

// File: rtl/sha256_core.sv
// sha256_core: SHA-256 compression engine with a byte-banked H/K constant store.
// Optional SHA256_CHAIN_EN adds FIRST to chain blocks from the previous DIGEST.
module sha256_hk_bank #(
    parameter int DEPTH = 72,
    parameter int AW    = 7
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] buffer [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) buffer[waddr_i] <= wdata_i;
        rdata_q <= buffer[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

module sha256_hk_mem #(
    parameter int DEPTH = 72,
    parameter int AW    = 7
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);
    sha256_hk_bank #(.DEPTH(DEPTH), .AW(AW)) bank_1 (
        .clk_i(clk_i), .we_i(we_i), .waddr_i(waddr_i),
        .wdata_i(wdata_i[31:24]), .raddr_i(raddr_i),
        .rdata_o(rdata_o[31:24])
    );
    sha256_hk_bank #(.DEPTH(DEPTH), .AW(AW)) bank_2 (
        .clk_i(clk_i), .we_i(we_i), .waddr_i(waddr_i),
        .wdata_i(wdata_i[23:16]), .raddr_i(raddr_i),
        .rdata_o(rdata_o[23:16])
    );
    sha256_hk_bank #(.DEPTH(DEPTH), .AW(AW)) bank_3 (
        .clk_i(clk_i), .we_i(we_i), .waddr_i(waddr_i),
        .wdata_i(wdata_i[15:8]), .raddr_i(raddr_i),
        .rdata_o(rdata_o[15:8])
    );
    sha256_hk_bank #(.DEPTH(DEPTH), .AW(AW)) bank_4 (
        .clk_i(clk_i), .we_i(we_i), .waddr_i(waddr_i),
        .wdata_i(wdata_i[7:0]), .raddr_i(raddr_i),
        .rdata_o(rdata_o[7:0])
    );
endmodule

module sha256_core #(
    parameter int HK_WORDS = 72,
    parameter int INIT_CYC = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
`ifdef SHA256_CHAIN_EN
    input  logic         FIRST,
`endif
    input  logic [511:0] BLOCK,
    output logic         INIT_DONE,
    output logic         BUSY,
    output logic         DONE,
    output logic [255:0] DIGEST
);
    localparam int AW = $clog2(HK_WORDS);

    localparam logic [2:0] MEM_INIT      = 3'd0;
    localparam logic [2:0] MEM_INIT_DONE = 3'd1;
    localparam logic [2:0] READY         = 3'd2;
    localparam logic [2:0] ROUND         = 3'd3;
    localparam logic [2:0] FINAL         = 3'd4;

    localparam logic [7:0] CYC_LAST = 8'(INIT_CYC - 1);

    // Words 0..7 are the IV, 8..71 are K0..K63.
    localparam logic [31:0] HK_ROM [HK_WORDS] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19,
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    logic [2:0]    state, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    cyc_q, cyc_d;
    logic          init_done_q, init_done_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [255:0]  digest_q, digest_d;
    logic [5:0]    t_q, t_d;
    logic [31:0]   wv_q [8];
    logic [31:0]   wv_d [8];
    logic [31:0]   w_q [16];
    logic [31:0]   w_d [16];
    logic [31:0]   iv_q [8];
    logic [31:0]   iv_d [8];
    logic [31:0]   h_src [8];
    logic          use_iv;
    logic          hk_we;
    logic [AW-1:0] rd_addr;
    logic [31:0]   k_word;
    logic [31:0]   t1, t2, w_new;

`ifdef SHA256_CHAIN_EN
    logic first_q, first_d;
    assign use_iv = (state == READY) ? FIRST : first_q;
`else
    assign use_iv = 1'b1;
`endif

    sha256_hk_mem #(.DEPTH(HK_WORDS), .AW(AW)) hk_mem (
        .clk_i   (CLK),
        .we_i    (hk_we),
        .waddr_i (addr_q),
        .wdata_i (HK_ROM[addr_q]),
        .raddr_i (rd_addr),
        .rdata_o (k_word)
    );

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            h_src[i] = use_iv ? iv_q[i] : digest_q[255-32*i -: 32];
        end
    end

    assign t1 = wv_q[7] + bsig1(wv_q[4])
              + ((wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]))
              + k_word + w_q[0];
    assign t2 = bsig0(wv_q[0])
              + ((wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2])
              ^ (wv_q[1] & wv_q[2]));
    assign w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

    always_comb begin
        state_d     = state;
        addr_d      = addr_q;
        cyc_d       = cyc_q;
        init_done_d = init_done_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        digest_d    = digest_q;
        t_d         = t_q;
        wv_d        = wv_q;
        w_d         = w_q;
        iv_d        = iv_q;
`ifdef SHA256_CHAIN_EN
        first_d     = first_q;
`endif
        hk_we       = 1'b0;
        // K0 sits on the read port whenever a block could start next.
        rd_addr     = AW'(8);
        unique case (state)
            MEM_INIT: begin
                if (cyc_q == CYC_LAST) begin
                    hk_we = 1'b1;
                    cyc_d = 8'd0;
                    if (addr_q < AW'(8)) iv_d[addr_q[2:0]] = HK_ROM[addr_q];
                    if (addr_q == AW'(HK_WORDS - 1)) begin
                        state_d     = MEM_INIT_DONE;
                        init_done_d = 1'b1;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end else begin
                    cyc_d = cyc_q + 8'd1;
                end
            end
            MEM_INIT_DONE: state_d = READY;
            READY: begin
                if (START) begin
                    busy_d  = 1'b1;
                    t_d     = 6'd0;
                    state_d = ROUND;
                    for (int i = 0; i < 16; i++) w_d[i] = BLOCK[511-32*i -: 32];
                    for (int i = 0; i < 8; i++) wv_d[i] = h_src[i];
`ifdef SHA256_CHAIN_EN
                    first_d = FIRST;
`endif
                end
            end
            ROUND: begin
                rd_addr = (t_q == 6'd63) ? AW'(8) : AW'(t_q) + AW'(9);
                wv_d[7] = wv_q[6];
                wv_d[6] = wv_q[5];
                wv_d[5] = wv_q[4];
                wv_d[4] = wv_q[3] + t1;
                wv_d[3] = wv_q[2];
                wv_d[2] = wv_q[1];
                wv_d[1] = wv_q[0];
                wv_d[0] = t1 + t2;
                for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
                w_d[15] = w_new;
                t_d     = t_q + 6'd1;
                if (t_q == 6'd63) state_d = FINAL;
            end
            FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    digest_d[255-32*i -: 32] = h_src[i] + wv_q[i];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = READY;
            end
            default: state_d = MEM_INIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= MEM_INIT;
            addr_q      <= '0;
            cyc_q       <= 8'd0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            digest_q    <= '0;
        end else begin
            state       <= state_d;
            addr_q      <= addr_d;
            cyc_q       <= cyc_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            digest_q    <= digest_d;
        end
    end

    always_ff @(posedge CLK) begin
        t_q  <= t_d;
        wv_q <= wv_d;
        w_q  <= w_d;
        iv_q <= iv_d;
`ifdef SHA256_CHAIN_EN
        first_q <= first_d;
`endif
    end

    assign INIT_DONE = init_done_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign DIGEST    = digest_q;
endmodule

// File: tb/tb_sha256_core.sv
// Directed bench for sha256_core: constant store, known digests, abort and init gating.
// Build with SHA256_CHAIN_EN to also run the two-block chained message.
`timescale 1ns/1ps
module tb_sha256_core;
    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic [511:0] BLOCK = '0;
`ifdef SHA256_CHAIN_EN
    logic         FIRST = 1'b1;
`endif
    logic         INIT_DONE;
    logic         BUSY;
    logic         DONE;
    logic [255:0] DIGEST;

    sha256_core dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
`ifdef SHA256_CHAIN_EN
        .FIRST     (FIRST),
`endif
        .BLOCK     (BLOCK),
        .INIT_DONE (INIT_DONE),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .DIGEST    (DIGEST)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string        name;
        logic [511:0] blk;
        logic [255:0] dig;
    } hvec_t;

    typedef struct {
        int          addr;
        logic [31:0] word;
    } mvec_t;

    hvec_t hv [2];
    mvec_t mv [10];
    int n_vec = 0;
    int n_bad = 0;

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] hk(input int i);
        return {dut.hk_mem.bank_1.buffer[i], dut.hk_mem.bank_2.buffer[i],
                dut.hk_mem.bank_3.buffer[i], dut.hk_mem.bank_4.buffer[i]};
    endfunction

    task automatic do_reset();
        RST   = 1'b1;
        START = 1'b0;
        @(posedge CLK); #1;
        check("rst_init_done", 256'(INIT_DONE), 256'(0));
        check("rst_busy", 256'(BUSY), 256'(0));
        check("rst_done", 256'(DONE), 256'(0));
        check("rst_digest", DIGEST, 256'(0));
        RST = 1'b0;
    endtask

    // Returns in MEM_INIT_DONE; optionally pulses START mid-init.
    task automatic wait_init(input bit pulse, output int cnt, output bit saw);
        cnt = 0;
        saw = 1'b0;
        while (!INIT_DONE && cnt < 200) begin
            START = pulse && (cnt >= 3) && (cnt <= 5);
            @(posedge CLK); #1;
            cnt++;
            if (BUSY || DONE) saw = 1'b1;
        end
        START = 1'b0;
    endtask

    task automatic run_block(input string name, input logic [511:0] blk,
                             input bit first, input bit chk_dig,
                             input logic [255:0] exp);
        int cnt;
`ifdef SHA256_CHAIN_EN
        FIRST = first;
`endif
        BLOCK = blk;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        cnt = 1;
        check({name, "_busy"}, 256'(BUSY), 256'(first | 1'b1));
        while (!DONE && cnt < 100) begin
            @(posedge CLK); #1;
            cnt++;
        end
        check({name, "_latency"}, 256'(cnt), 256'(66));
        check({name, "_busy_at_done"}, 256'(BUSY), 256'(0));
        if (chk_dig) check({name, "_digest"}, DIGEST, exp);
        @(posedge CLK); #1;
        check({name, "_done_pulse"}, 256'(DONE), 256'(0));
        if (chk_dig) check({name, "_digest_held"}, DIGEST, exp);
    endtask

    initial begin
        int  cnt;
        bit  saw;
        hv[0] = '{"abc", ABC_BLK, ABC_DIG};
        hv[1] = '{"empty", {32'h80000000, 480'h0},
            256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855};
        mv[0] = '{0, 32'h6a09e667};
        mv[1] = '{1, 32'hbb67ae85};
        mv[2] = '{2, 32'h3c6ef372};
        mv[3] = '{3, 32'ha54ff53a};
        mv[4] = '{4, 32'h510e527f};
        mv[5] = '{5, 32'h9b05688c};
        mv[6] = '{6, 32'h1f83d9ab};
        mv[7] = '{7, 32'h5be0cd19};
        mv[8] = '{8, 32'h428a2f98};
        mv[9] = '{71, 32'hc67178f2};

        do_reset();
        wait_init(1'b1, cnt, saw);
        check("init_done_by_74", 256'(cnt >= 72 && cnt <= 74), 256'(1));
        check("start_in_init_ignored", 256'(saw), 256'(0));
        for (int i = 0; i < 10; i++) begin
            check($sformatf("hk_mem[%0d]", mv[i].addr), 256'(hk(mv[i].addr)),
                  256'(mv[i].word));
        end
        @(posedge CLK); #1;

        for (int i = 0; i < 2; i++) begin
            run_block(hv[i].name, hv[i].blk, 1'b1, 1'b1, hv[i].dig);
        end

        BLOCK = ABC_BLK;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK); #1;
            if (DONE) saw = 1'b1;
        end
        do_reset();
        wait_init(1'b0, cnt, saw);
        check("abort_no_done", 256'(saw), 256'(0));
        check("reinit_done", 256'(INIT_DONE), 256'(1));
        @(posedge CLK); #1;
        run_block("abc_after_abort", ABC_BLK, 1'b1, 1'b1, ABC_DIG);

`ifdef SHA256_CHAIN_EN
        run_block("two_blk_1", {32'h61626364, 32'h62636465, 32'h63646566,
            32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
            32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e,
            32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000,
            32'h00000000}, 1'b1, 1'b0, 256'(0));
        run_block("two_blk_2", {480'h0, 32'h000001c0}, 1'b0, 1'b1,
            256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
